// File: rtl/pipe_pkg.sv
// Shared definitions for the core pipeline: RV32 opcode constants used by the
// decoder and the hazard logic, the sequencer state encoding, and helpers that
// tell which register sources an opcode reads.
package pipe_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_e;

    // rs1 is read by loads, stores, ALU ops, branches and jalr.
    function automatic logic uses_rs1(input logic [6:0] op);
        logic used;
        case (op)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JALR: used = 1'b1;
            default:                                       used = 1'b0;
        endcase
        return used;
    endfunction

    // rs2 is read only by stores, register-register ALU ops and branches;
    // in the other formats bits [24:20] hold immediate bits.
    function automatic logic uses_rs2(input logic [6:0] op);
        logic used;
        case (op)
            OP_STORE, OP_R, OP_BR: used = 1'b1;
            default:               used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detector: flags when the ID-stage instruction reads the
// register a load in EXE is about to write. Purely combinational so it can be
// shared with the forwarding unit.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [31:0] i_id_instr,
    input  logic        i_exe_is_load,
    input  logic [4:0]  i_exe_rd,
    output logic        o_hazard
);

    logic [6:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_rs1_hit;
    logic       w_rs2_hit;
    logic       w_unused_bits;

    assign w_opcode = i_id_instr[6:0];
    assign w_rs1    = i_id_instr[19:15];
    assign w_rs2    = i_id_instr[24:20];

    // funct/rd/immediate fields play no part in the hazard decision
    assign w_unused_bits = ^{i_id_instr[31:25], i_id_instr[14:7]};

    assign w_rs1_hit = uses_rs1(w_opcode) && (w_rs1 == i_exe_rd);
    assign w_rs2_hit = uses_rs2(w_opcode) && (w_rs2 == i_exe_rd);

    // x0 is never really written, so a load targeting it cannot create a hazard
    assign o_hazard = i_exe_is_load && (i_exe_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 4-stage core. Owns the single stall/flush policy:
// load-use bubbles, post-redirect squashing and multi-cycle data-memory waits.
// Outputs are Mealy so a stall acts in the same cycle the hazard is visible.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] id_instr,
    input  logic        exe_is_load,
    input  logic [4:0]  exe_rd,
    input  logic        redirect,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        pc_hold,
    output logic        ide_wait,
    output logic        flush_if,
    output logic        exe_hold,
    output logic [31:0] perf_stall
);

    // cnt holds the number of cycles still to be spent in LD_STALL / FLUSH
    localparam logic [1:0] LB_INIT = 2'(LOAD_BUBBLES - 1);
    localparam logic [1:0] FL_INIT = 2'(FLUSH_CYCLES - 1);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic        r_redirect_pend;
    logic        w_pend_nxt;
    logic [31:0] r_perf_stall;

    logic        w_hazard;
    logic        w_memwait;

    // one-hot action selected for this cycle
    logic        w_act_mem;
    logic        w_act_redir;
    logic        w_act_haz;
    logic        w_act_ld_cont;
    logic        w_act_fl_cont;

    hazard_detect u_hazard_detect (
        .i_id_instr    (id_instr),
        .i_exe_is_load (exe_is_load),
        .i_exe_rd      (exe_rd),
        .o_hazard      (w_hazard)
    );

    assign w_memwait  = dmem_req && !dmem_ack;
    assign perf_stall = r_perf_stall;

    // Action selection per state: memwait > redirect (or pending one) > hazard
    always_comb begin
        w_act_mem     = 1'b0;
        w_act_redir   = 1'b0;
        w_act_haz     = 1'b0;
        w_act_ld_cont = 1'b0;
        w_act_fl_cont = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_memwait)     w_act_mem   = 1'b1;
                else if (redirect) w_act_redir = 1'b1;
                else if (w_hazard) w_act_haz   = 1'b1;
                else               w_act_mem   = 1'b0;
            end
            ST_LD_STALL: begin
                if (w_memwait)     w_act_mem     = 1'b1;
                else if (redirect) w_act_redir   = 1'b1;
                else               w_act_ld_cont = 1'b1;
            end
            ST_FLUSH: begin
                if (w_memwait)     w_act_mem     = 1'b1;
                else if (redirect) w_act_redir   = 1'b1;
                else               w_act_fl_cont = 1'b1;
            end
            ST_MEM_WAIT: begin
                if (w_memwait)                       w_act_mem   = 1'b1;
                else if (r_redirect_pend || redirect) w_act_redir = 1'b1;
                else if (w_hazard)                    w_act_haz   = 1'b1;
                else                                  w_act_mem   = 1'b0;
            end
            default: w_act_mem = 1'b0;
        endcase
    end

    // Outputs and next state for the selected action; all quiet while in reset
    always_comb begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 2'd0;
        w_pend_nxt  = 1'b0;
        pc_hold     = 1'b0;
        ide_wait    = 1'b0;
        flush_if    = 1'b0;
        exe_hold    = 1'b0;
        if (!rstn) begin
            w_state_nxt = ST_RUN;
        end else if (w_act_mem) begin
            pc_hold     = 1'b1;
            ide_wait    = 1'b1;
            exe_hold    = 1'b1;
            w_state_nxt = ST_MEM_WAIT;
            w_cnt_nxt   = r_cnt;
            // a flush interrupted by the wait must still be completed afterwards
            w_pend_nxt  = r_redirect_pend || redirect || (r_state == ST_FLUSH);
        end else if (w_act_redir) begin
            flush_if    = 1'b1;
            ide_wait    = 1'b1;
            w_cnt_nxt   = FL_INIT;
            w_state_nxt = (FL_INIT != 2'd0) ? ST_FLUSH : ST_RUN;
        end else if (w_act_haz) begin
            pc_hold     = 1'b1;
            ide_wait    = 1'b1;
            w_cnt_nxt   = LB_INIT;
            w_state_nxt = (LB_INIT != 2'd0) ? ST_LD_STALL : ST_RUN;
        end else if (w_act_ld_cont || w_act_fl_cont) begin
            pc_hold     = w_act_ld_cont;
            flush_if    = w_act_fl_cont;
            ide_wait    = 1'b1;
            if (r_cnt <= 2'd1) begin
                w_cnt_nxt   = 2'd0;
                w_state_nxt = ST_RUN;
            end else begin
                w_cnt_nxt   = r_cnt - 2'd1;
                w_state_nxt = r_state;
            end
        end else begin
            w_state_nxt = ST_RUN;
        end
    end

    // State, countdown and pending-redirect registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= ST_RUN;
            r_cnt           <= 2'd0;
            r_redirect_pend <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_redirect_pend <= w_pend_nxt;
        end
    end

    // Stall-cycle performance counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_stall <= 32'd0;
        end else if (pc_hold) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end else begin
            r_perf_stall <= r_perf_stall;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (LOAD_BUBBLES=1,
// FLUSH_CYCLES=2). obs packs {pc_hold, ide_wait, flush_if, exe_hold}.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] id_instr;
    logic        exe_is_load;
    logic [4:0]  exe_rd;
    logic        redirect;
    logic        dmem_req;
    logic        dmem_ack;
    logic        pc_hold;
    logic        ide_wait;
    logic        flush_if;
    logic        exe_hold;
    logic [31:0] perf_stall;
    logic [3:0]  obs;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] ADD_X6_X5_X7 = {7'b0, 5'd7, 5'd5, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] LUI_X5       = {20'h00028, 5'd5, 7'b0110111};

    pipe_hazard_ctrl #(.LOAD_BUBBLES(1), .FLUSH_CYCLES(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .id_instr    (id_instr),
        .exe_is_load (exe_is_load),
        .exe_rd      (exe_rd),
        .redirect    (redirect),
        .dmem_req    (dmem_req),
        .dmem_ack    (dmem_ack),
        .pc_hold     (pc_hold),
        .ide_wait    (ide_wait),
        .flush_if    (flush_if),
        .exe_hold    (exe_hold),
        .perf_stall  (perf_stall)
    );

    assign obs = {pc_hold, ide_wait, flush_if, exe_hold};

    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_instr    = 32'd0;
        exe_is_load = 1'b0;
        exe_rd      = 5'd0;
        redirect    = 1'b0;
        dmem_req    = 1'b0;
        dmem_ack    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        @(negedge clk);
        rstn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            id_instr    = $urandom;
            exe_is_load = 1'($urandom_range(0, 1));
            exe_rd      = 5'($urandom_range(0, 31));
            redirect    = 1'($urandom_range(0, 1));
            dmem_req    = 1'($urandom_range(0, 1));
            dmem_ack    = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (obs !== 4'b0000 || perf_stall !== 32'd0)
                $display("FAIL reset_hold[%0d]: got obs=%b perf=%0d want obs=0000 perf=0", i, obs, perf_stall);
            if (obs !== 4'b0000 || perf_stall !== 32'd0) errors++;
        end
        idle_inputs();
        @(negedge clk);
        rstn = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 4'b0000 || perf_stall !== 32'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got obs=%b perf=%0d want obs=0000 perf=0", i, obs, perf_stall);
            end
            step();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        id_instr = ADD_X6_X5_X7; exe_is_load = 1'b1; exe_rd = 5'd5;
        @(negedge clk);
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL load_use_stall: got obs=%b want 1100", obs);
        end
        step();
        exe_is_load = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 4'b0000 || perf_stall !== 32'd1) begin
            errors++;
            $display("FAIL load_use_release: got obs=%b perf=%0d want obs=0000 perf=1", obs, perf_stall);
        end
        step();
        exe_is_load = 1'b1; exe_rd = 5'd0;
        @(negedge clk);
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL load_use_x0: got obs=%b want 0000", obs);
        end
        step();
        id_instr = LUI_X5; exe_rd = 5'd5;
        @(negedge clk);
        checks++;
        if (obs !== 4'b0000 || perf_stall !== 32'd1) begin
            errors++;
            $display("FAIL load_use_lui: got obs=%b perf=%0d want obs=0000 perf=1", obs, perf_stall);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_source_usage();
        logic [31:0] instrs [12];
        logic        exp    [12];
        instrs[0]  = ADD_X6_X5_X7;                                          exp[0]  = 1'b1;
        instrs[1]  = {7'b0, 5'd5, 5'd7, 3'b000, 5'd6, 7'b0110011};          exp[1]  = 1'b1;
        instrs[2]  = {12'h005, 5'd7, 3'b000, 5'd6, 7'b0010011};             exp[2]  = 1'b0;
        instrs[3]  = {7'b0, 5'd5, 5'd1, 3'b010, 5'd0, 7'b0100011};          exp[3]  = 1'b1;
        instrs[4]  = {7'b0, 5'd5, 5'd1, 3'b000, 5'd0, 7'b1100011};          exp[4]  = 1'b1;
        instrs[5]  = {12'h000, 5'd5, 3'b010, 5'd6, 7'b0000011};             exp[5]  = 1'b1;
        instrs[6]  = {12'h000, 5'd5, 3'b000, 5'd1, 7'b1100111};             exp[6]  = 1'b1;
        instrs[7]  = {20'h00028, 5'd1, 7'b1101111};                         exp[7]  = 1'b0;
        instrs[8]  = {20'h00028, 5'd1, 7'b0010111};                         exp[8]  = 1'b0;
        instrs[9]  = LUI_X5;                                                exp[9]  = 1'b0;
        instrs[10] = {7'b0, 5'd5, 5'd5, 3'b000, 5'd5, 7'b1111111};          exp[10] = 1'b0;
        instrs[11] = {7'b0, 5'd5, 5'd1, 3'b000, 5'd1, 7'b1100111};          exp[11] = 1'b0;
        do_reset();
        exe_is_load = 1'b1; exe_rd = 5'd5;
        for (int i = 0; i < 12; i++) begin
            id_instr = instrs[i];
            @(negedge clk);
            checks++;
            if (obs !== {exp[i], exp[i], 2'b00}) begin
                errors++;
                $display("FAIL source_usage[%0d] instr=%h: got obs=%b want %b", i, instrs[i], obs, {exp[i], exp[i], 2'b00});
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_redirect();
        logic [3:0] exp_a [3];
        logic [3:0] exp_b [4];
        exp_a[0] = 4'b0110; exp_a[1] = 4'b0110; exp_a[2] = 4'b0000;
        exp_b[0] = 4'b0110; exp_b[1] = 4'b0110; exp_b[2] = 4'b0110; exp_b[3] = 4'b0000;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            redirect = (c == 0);
            @(negedge clk);
            checks++;
            if (obs !== exp_a[c]) begin
                errors++;
                $display("FAIL redirect_single c%0d: got obs=%b want %b", c, obs, exp_a[c]);
            end
            step();
        end
        for (int c = 0; c < 4; c++) begin
            redirect = (c == 0) || (c == 1);
            @(negedge clk);
            checks++;
            if (obs !== exp_b[c]) begin
                errors++;
                $display("FAIL redirect_extend c%0d: got obs=%b want %b", c, obs, exp_b[c]);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        dmem_req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            dmem_ack = (c == 4);
            dmem_req = (c <= 4);
            @(negedge clk);
            checks++;
            if (obs !== ((c < 4) ? 4'b1101 : 4'b0000)) begin
                errors++;
                $display("FAIL mem_wait c%0d: got obs=%b want %b", c, obs, (c < 4) ? 4'b1101 : 4'b0000);
            end
            step();
        end
        checks++;
        if (perf_stall !== 32'd4) begin
            errors++;
            $display("FAIL mem_wait_perf: got %0d want 4", perf_stall);
        end
        idle_inputs();
    endtask

    task automatic test_redirect_in_mem_wait();
        logic [3:0] exp [6];
        exp[0] = 4'b1101; exp[1] = 4'b1101; exp[2] = 4'b1101;
        exp[3] = 4'b0110; exp[4] = 4'b0110; exp[5] = 4'b0000;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            dmem_req = (c <= 3);
            dmem_ack = (c == 3);
            redirect = (c == 1);
            @(negedge clk);
            checks++;
            if (obs !== exp[c]) begin
                errors++;
                $display("FAIL redirect_mem_wait c%0d: got obs=%b want %b", c, obs, exp[c]);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_hazard_and_redirect();
        logic [3:0] exp [3];
        exp[0] = 4'b0110; exp[1] = 4'b0110; exp[2] = 4'b1100;
        do_reset();
        id_instr = ADD_X6_X5_X7; exe_is_load = 1'b1; exe_rd = 5'd5;
        for (int c = 0; c < 3; c++) begin
            redirect = (c == 0);
            @(negedge clk);
            checks++;
            if (obs !== exp[c]) begin
                errors++;
                $display("FAIL hazard_redirect c%0d: got obs=%b want %b", c, obs, exp[c]);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        // reset in the middle of a flush
        do_reset();
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        rstn = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_flush: got obs=%b want 0000", obs);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_flush_release: got obs=%b want 0000", obs);
        end
        step();
        // reset while a redirect is pending behind a memory wait
        dmem_req = 1'b1;
        step();
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        step();
        rstn = 1'b0;
        dmem_req = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0000 || perf_stall !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_mem: got obs=%b perf=%0d want obs=0000 perf=0", obs, perf_stall);
        end
        @(negedge clk);
        rstn = 1'b1;
        step();
        dmem_req = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 4'b1101) begin
            errors++;
            $display("FAIL reset_mid_new_wait: got obs=%b want 1101", obs);
        end
        step();
        dmem_req = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_no_pending: got obs=%b want 0000", obs);
        end
        step();
        idle_inputs();
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        step();
        test_reset();
        test_load_use();
        test_source_usage();
        test_redirect();
        test_mem_wait();
        test_redirect_in_mem_wait();
        test_hazard_and_redirect();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
